// File: rtl/obstacle_pkg.sv
// Shared constants and LFSR step function for the obstacle pool.
package obstacle_pkg;

  localparam int LFSR_W = 16;
  // Galois right-shift form of x^16+x^14+x^13+x^11+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 10;
  localparam int DEF_Y_LIMIT = 480;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: active flag plus x/y position, advanced by upsig and retired at Y_LIMIT.
module obstacle_slot
  import obstacle_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int Y_LIMIT = DEF_Y_LIMIT,
  parameter int SPEED   = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           kill,
  input  logic           upsig,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  output logic           on,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [Y_W:0] LIMIT = (Y_W+1)'(Y_LIMIT);
  localparam logic [Y_W:0] STEP  = (Y_W+1)'(SPEED);

  logic [Y_W:0] y_adv;

  assign y_adv = {1'b0, y} + STEP;

  // Kill has priority over a load and over the advance; a retiring slot keeps its last y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on <= 1'b0;
      x  <= '0;
      y  <= '0;
    end else if (kill) begin
      on <= 1'b0;
    end else if (load) begin
      on <= 1'b1;
      x  <= load_x;
      y  <= '0;
    end else if (on && upsig) begin
      if (y_adv >= LIMIT) begin
        on <= 1'b0;
      end else begin
        y <= y_adv[Y_W-1:0];
      end
    end
  end

endmodule

// File: rtl/obstacle_pool.sv
// Pool of falling obstacles with rate-limited spawning at pseudo-random x positions.
// Optional feature: define OBSTACLE_POOL_STEER_EN to mix left/right into the LFSR.
module obstacle_pool
  import obstacle_pkg::*;
#(
  parameter int                N_SLOTS   = 6,
  parameter int                X_W       = DEF_X_W,
  parameter int                Y_W       = DEF_Y_W,
  parameter int                X_MIN     = 16,
  parameter int                X_MASK    = 'h7F,
  parameter int                Y_LIMIT   = DEF_Y_LIMIT,
  parameter int                SPEED     = 1,
  parameter int                SPACING   = 64,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   drop,
  input  logic                   upsig,
  input  logic                   left,
  input  logic                   right,
  input  logic [N_SLOTS-1:0]     kill,
  output logic                   spawn_ack,
  output logic                   full,
  output logic [N_SLOTS-1:0]     obstacle_on,
  output logic [N_SLOTS*X_W-1:0] obstacle_x,
  output logic [N_SLOTS*Y_W-1:0] obstacle_y
);

  localparam int CD_W = (SPACING > 1) ? $clog2(SPACING) : 1;

  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_nxt;
  logic [CD_W-1:0]    cooldown;
  logic [N_SLOTS-1:0] free;
  logic [N_SLOTS-1:0] load_vec;
  logic               spawn;
  logic [X_W-1:0]     spawn_x;

  assign full    = &obstacle_on;
  assign spawn_x = X_W'(X_MIN) + (lfsr[X_W-1:0] & X_W'(X_MASK));

  // A slot being killed this edge is not offered for spawning; lowest free index wins
  assign free     = ~obstacle_on & ~kill;
  assign spawn    = drop && (cooldown == '0) && (|free);
  assign load_vec = spawn ? (free & (~free + N_SLOTS'(1))) : '0;

  always_comb begin
    lfsr_nxt = lfsr_next(lfsr);
`ifdef OBSTACLE_POOL_STEER_EN
    lfsr_nxt[0] = lfsr_nxt[0] ^ (left ^ right);
    lfsr_nxt[7] = lfsr_nxt[7] ^ left;
    if (lfsr_nxt == '0) lfsr_nxt = LFSR_SEED;
`endif
  end

`ifdef OBSTACLE_POOL_STEER_EN
`else
  logic unused_steer;
  assign unused_steer = left ^ right;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= LFSR_SEED;
      cooldown  <= '0;
      spawn_ack <= 1'b0;
    end else begin
      lfsr      <= lfsr_nxt;
      spawn_ack <= spawn;
      if (spawn) begin
        cooldown <= CD_W'(SPACING - 1);
      end else if (cooldown != '0) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    obstacle_slot #(
      .X_W    (X_W),
      .Y_W    (Y_W),
      .Y_LIMIT(Y_LIMIT),
      .SPEED  (SPEED)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .kill  (kill[g]),
      .upsig (upsig),
      .load  (load_vec[g]),
      .load_x(spawn_x),
      .on    (obstacle_on[g]),
      .x     (obstacle_x[g*X_W +: X_W]),
      .y     (obstacle_y[g*Y_W +: Y_W])
    );
  end

endmodule

// File: tb/tb_obstacle_pool.sv
// Directed self-checking bench for obstacle_pool (N_SLOTS=6, SPACING=4, default build).
module tb_obstacle_pool;

  logic        clk = 1'b0;
  logic        reset;
  logic        drop;
  logic        upsig;
  logic        left;
  logic        right;
  logic [5:0]  kill;
  logic        spawn_ack;
  logic        full;
  logic [5:0]  obstacle_on;
  logic [47:0] obstacle_x;
  logic [59:0] obstacle_y;

  int checks   = 0;
  int failures = 0;

  logic [15:0] tb_lfsr;
  logic [7:0]  model_x;

  obstacle_pool #(
    .N_SLOTS  (6),
    .X_W      (8),
    .Y_W      (10),
    .X_MIN    (16),
    .X_MASK   ('h7F),
    .Y_LIMIT  (480),
    .SPEED    (1),
    .SPACING  (4),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .drop       (drop),
    .upsig      (upsig),
    .left       (left),
    .right      (right),
    .kill       (kill),
    .spawn_ack  (spawn_ack),
    .full       (full),
    .obstacle_on(obstacle_on),
    .obstacle_x (obstacle_x),
    .obstacle_y (obstacle_y)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [7:0] x_of(input int s);
    return obstacle_x[s*8 +: 8];
  endfunction

  function automatic logic [9:0] y_of(input int s);
    return obstacle_y[s*10 +: 10];
  endfunction

  // One clock edge: the reference LFSR is sampled before it advances, like the DUT
  task automatic applyStimulus();
    @(posedge clk);
    model_x = 8'd16 + (tb_lfsr[7:0] & 8'h7F);
    tb_lfsr = ref_lfsr(tb_lfsr);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic exp_ack;
    reset   = 1'b1;
    drop    = 1'b0;
    upsig   = 1'b0;
    left    = 1'b0;
    right   = 1'b0;
    kill    = '0;
    tb_lfsr = 16'hACE1;
    #12;
    checkOutput("rst_on",  32'(obstacle_on), 32'h0);
    checkOutput("rst_x",   32'(obstacle_x != '0), 32'h0);
    checkOutput("rst_y",   32'(obstacle_y != '0), 32'h0);
    checkOutput("rst_ack", 32'(spawn_ack), 32'h0);
    checkOutput("rst_full", 32'(full), 32'h0);

    // Drop held from release: spawns every 4th edge into slots 0..5
    @(posedge clk);
    #1;
    reset   = 1'b0;
    drop    = 1'b1;
    tb_lfsr = 16'hACE1;
    for (int e = 1; e <= 24; e++) begin
      applyStimulus();
      exp_ack = ((e % 4) == 1) && (e <= 21);
      checkOutput("fill_ack", 32'(spawn_ack), 32'(exp_ack));
      if (exp_ack) begin
        checkOutput("fill_on", 32'(obstacle_on), (32'h1 << ((e - 1) / 4 + 1)) - 1);
        checkOutput("fill_x", 32'(x_of((e - 1) / 4)), 32'(model_x));
        checkOutput("fill_x_range", 32'((x_of((e - 1) / 4) >= 8'd16) && (x_of((e - 1) / 4) <= 8'd143)), 32'h1);
        if (e == 1) checkOutput("first_x", 32'(x_of(0)), 32'd113);
        if (e == 5) checkOutput("second_x", 32'(x_of(1)), 32'd94);
      end
    end
    checkOutput("fill_full", 32'(full), 32'h1);
    checkOutput("fill_on_all", 32'(obstacle_on), 32'h3F);

    // Kill slot 2 while full: clears, then respawns on the following edge
    kill = 6'b000100;
    applyStimulus();
    checkOutput("kill_on", 32'(obstacle_on), 32'h3B);
    checkOutput("kill_ack", 32'(spawn_ack), 32'h0);
    checkOutput("kill_full", 32'(full), 32'h0);
    kill = '0;
    applyStimulus();
    checkOutput("respawn_ack", 32'(spawn_ack), 32'h1);
    checkOutput("respawn_on", 32'(obstacle_on), 32'h3F);
    checkOutput("respawn_y", 32'(y_of(2)), 32'h0);
    checkOutput("respawn_x", 32'(x_of(2)), 32'(model_x));
    drop = 1'b0;

    // Advance everything to y=100, then kill slot 1 on an upsig edge
    upsig = 1'b1;
    repeat (100) applyStimulus();
    checkOutput("adv_y2", 32'(y_of(2)), 32'd100);
    kill = 6'b000010;
    applyStimulus();
    checkOutput("killup_on", 32'(obstacle_on), 32'h3D);
    checkOutput("killup_y1", 32'(y_of(1)), 32'd100);
    checkOutput("killup_y0", 32'(y_of(0)), 32'd101);
    kill  = '0;
    upsig = 1'b0;

    // Refill slot 1 so the cooldown is loaded, then reset asynchronously mid-cycle
    drop = 1'b1;
    applyStimulus();
    checkOutput("refill_ack", 32'(spawn_ack), 32'h1);
    checkOutput("refill_on", 32'(obstacle_on), 32'h3F);
    drop = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_on", 32'(obstacle_on), 32'h0);
    checkOutput("arst_x", 32'(obstacle_x != '0), 32'h0);
    checkOutput("arst_y", 32'(obstacle_y != '0), 32'h0);
    checkOutput("arst_ack", 32'(spawn_ack), 32'h0);
    checkOutput("arst_full", 32'(full), 32'h0);

    // First edge after release spawns; upsig on that edge leaves y at 0
    @(posedge clk);
    #1;
    reset   = 1'b0;
    drop    = 1'b1;
    upsig   = 1'b1;
    tb_lfsr = 16'hACE1;
    applyStimulus();
    checkOutput("post_ack", 32'(spawn_ack), 32'h1);
    checkOutput("post_on", 32'(obstacle_on), 32'h1);
    checkOutput("post_x", 32'(x_of(0)), 32'd113);
    checkOutput("post_y", 32'(y_of(0)), 32'h0);
    drop = 1'b0;

    // 480 upsig pulses in total: 479 climb, the last retires without moving
    repeat (479) applyStimulus();
    checkOutput("climb_y", 32'(y_of(0)), 32'd479);
    checkOutput("climb_on", 32'(obstacle_on), 32'h1);
    applyStimulus();
    checkOutput("retire_on", 32'(obstacle_on), 32'h0);
    checkOutput("retire_y", 32'(y_of(0)), 32'd479);
    upsig = 1'b0;

    // Freed slot is reusable; a second drop right after is blocked by cooldown
    drop = 1'b1;
    applyStimulus();
    checkOutput("reuse_ack", 32'(spawn_ack), 32'h1);
    checkOutput("reuse_on", 32'(obstacle_on), 32'h1);
    checkOutput("reuse_y", 32'(y_of(0)), 32'h0);
    applyStimulus();
    checkOutput("cool_ack", 32'(spawn_ack), 32'h0);
    checkOutput("cool_on", 32'(obstacle_on), 32'h1);
    drop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
